// File: rtl/crc32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crc32_pkg
//  Description : Shared constants and FSM state type for the Ethernet
//                CRC-32 FCS generator and checker.
//  Revision    : 1.0 - initial release
// ============================================================================
package crc32_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT    = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        FCS     = 2'd2
    } state_t;

endpackage : crc32_pkg
`default_nettype wire

// File: rtl/crc32_byte.sv
`default_nettype none
// ============================================================================
//  Module      : crc32_byte
//  Description : Combinational reflected CRC-32 update, one byte per step,
//                bits consumed LSB-first. Shared by the FCS generator and the
//                receive-side checker.
//  Revision    : 1.0 - initial release
// ============================================================================
module crc32_byte
    import crc32_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data_byte,
    output logic [31:0] crc_next
);

    // Fold the byte into the low bits, then shift out eight bits through the
    // reflected polynomial.
    always_comb begin
        logic [31:0] w_c;
        w_c = crc ^ {24'h000000, data_byte};
        for (int i = 0; i < 8; i++) begin
            if (w_c[0]) begin
                w_c = (w_c >> 1) ^ CRC32_POLY_REFL;
            end else begin
                w_c = w_c >> 1;
            end
        end
        crc_next = w_c;
    end

endmodule : crc32_byte
`default_nettype wire

// File: rtl/crc32_append.sv
`default_nettype none
// ============================================================================
//  Module      : crc32_append
//  Description : Transmit-side Ethernet FCS generator. Forwards framed
//                payload bytes with one cycle of latency and appends the
//                4-byte CRC-32 FCS, least significant byte first.
//  Revision    : 1.0 - initial release
// ============================================================================
module crc32_append
    import crc32_pkg::*;
#(
    parameter int BUS_WIDTH = 8,
    parameter int CRC_BITS  = 32
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sof,
    input  logic                 eof,
    input  logic                 data_v,
    input  logic [BUS_WIDTH-1:0] data,
    output logic                 in_ready,
    output logic                 out_sof,
    output logic                 out_eof,
    output logic                 out_v,
    output logic [BUS_WIDTH-1:0] out_data,
    output logic                 abort
);

    state_t                r_state;
    state_t                w_state_next;
    logic [CRC_BITS-1:0]   r_crc;
    logic [CRC_BITS-1:0]   w_crc_next;
    logic [CRC_BITS-1:0]   w_crc_seed;
    logic [CRC_BITS-1:0]   w_crc_step;
    logic [CRC_BITS-1:0]   w_fcs;
    logic [1:0]            r_k;
    logic [1:0]            w_k_next;
    logic                  w_accept;

    logic                  w_out_v;
    logic                  w_out_sof;
    logic                  w_out_eof;
    logic                  w_abort;
    logic [BUS_WIDTH-1:0]  w_out_data;

    // The source is held off only while the FCS bytes are being emitted.
    assign in_ready = (r_state != FCS);
    assign w_accept = data_v && in_ready;

    // A sof byte always restarts the running CRC from the initial value.
    assign w_crc_seed = sof ? CRC32_INIT : r_crc;
    assign w_fcs      = r_crc ^ CRC32_XOROUT;

    crc32_byte u_crc32_byte (
        .crc       (w_crc_seed),
        .data_byte (data),
        .crc_next  (w_crc_step)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && sof) begin
                    w_state_next = eof ? FCS : PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (w_accept && eof) begin
                    w_state_next = FCS;
                end
            end
            FCS: begin
                if (r_k == 2'd3) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Output and datapath decode: next values of the output registers,
    // the running CRC and the FCS byte counter.
    always_comb begin
        w_out_v    = 1'b0;
        w_out_sof  = 1'b0;
        w_out_eof  = 1'b0;
        w_abort    = 1'b0;
        w_out_data = '0;
        w_crc_next = r_crc;
        w_k_next   = r_k;
        case (r_state)
            IDLE: begin
                // Bytes outside a frame are dropped silently.
                if (w_accept && sof) begin
                    w_out_v    = 1'b1;
                    w_out_sof  = 1'b1;
                    w_out_data = data;
                    w_crc_next = w_crc_step;
                    w_k_next   = 2'd0;
                end
            end
            PAYLOAD: begin
                if (w_accept) begin
                    w_out_v    = 1'b1;
                    w_out_sof  = sof;
                    w_abort    = sof;
                    w_out_data = data;
                    w_crc_next = w_crc_step;
                    w_k_next   = 2'd0;
                end
            end
            FCS: begin
                w_out_v   = 1'b1;
                w_out_eof = (r_k == 2'd3);
                case (r_k)
                    2'd0:    w_out_data = w_fcs[7:0];
                    2'd1:    w_out_data = w_fcs[15:8];
                    2'd2:    w_out_data = w_fcs[23:16];
                    default: w_out_data = w_fcs[31:24];
                endcase
                w_k_next = r_k + 2'd1;
                if (r_k == 2'd3) begin
                    w_crc_next = CRC32_INIT;
                end
            end
            default: begin
                w_crc_next = CRC32_INIT;
                w_k_next   = 2'd0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc    <= CRC32_INIT;
            r_k      <= 2'd0;
            out_v    <= 1'b0;
            out_sof  <= 1'b0;
            out_eof  <= 1'b0;
            abort    <= 1'b0;
            out_data <= '0;
        end else begin
            r_crc    <= w_crc_next;
            r_k      <= w_k_next;
            out_v    <= w_out_v;
            out_sof  <= w_out_sof;
            out_eof  <= w_out_eof;
            abort    <= w_abort;
            out_data <= w_out_data;
        end
    end

endmodule : crc32_append
`default_nettype wire

// File: tb/tb_crc32_append.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crc32_append
//  Description : Self-checking bench for crc32_append: known-answer frame
//                table, hand-written corner sequences and random frames
//                checked against a bit-serial CRC model and the receive
//                residue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crc32_append;

    localparam logic [31:0] POLY    = 32'hEDB88320;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sof = 1'b0;
    logic       eof = 1'b0;
    logic       data_v = 1'b0;
    logic [7:0] data = 8'h00;
    logic       in_ready;
    logic       out_sof;
    logic       out_eof;
    logic       out_v;
    logic [7:0] out_data;
    logic       abort;

    crc32_append #(.BUS_WIDTH(8), .CRC_BITS(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sof      (sof),
        .eof      (eof),
        .data_v   (data_v),
        .data     (data),
        .in_ready (in_ready),
        .out_sof  (out_sof),
        .out_eof  (out_eof),
        .out_v    (out_v),
        .out_data (out_data),
        .abort    (abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       s;
        logic       e;
        logic       a;
        int         cyc;
    } rec_t;

    typedef struct {
        logic [7:0]  bytes[16];
        int          len;
        int          gap_after;
        int          gap_len;
        logic [31:0] fcs;
    } vec_t;

    rec_t obs_q[$];
    rec_t exp_q[$];
    int   cyc       = 0;
    int   eof_cnt   = 0;
    int   abort_cnt = 0;
    int   rdy_low   = 0;
    int   stray     = 0;
    int   last_acc  = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampling mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_v) begin
                obs_q.push_back('{d: out_data, s: out_sof, e: out_eof, a: abort, cyc: cyc});
            end
            if (out_eof && out_v) eof_cnt++;
            if (abort) abort_cnt++;
            if (!in_ready) rdy_low++;
            if ((abort || out_sof || out_eof) && !out_v) stray++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Bit-serial reflected CRC register (before output inversion).
    function automatic logic [31:0] crc_raw(input logic [7:0] q[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            for (int b = 0; b < 8; b++) begin
                if (c[0] ^ q[i][b]) c = (c >> 1) ^ POLY;
                else                c = c >> 1;
            end
        end
        return c;
    endfunction

    task automatic push_exp(input logic [7:0] d, input logic s, input logic e, input logic a);
        exp_q.push_back('{d: d, s: s, e: e, a: a, cyc: 0});
    endtask

    task automatic build_frame_exp(input logic [7:0] q[$], input logic [31:0] fcs);
        logic [31:0] f;
        f = fcs;
        foreach (q[i]) push_exp(q[i], i == 0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) push_exp(f[8*k +: 8], 1'b0, k == 3, 1'b0);
    endtask

    // Present one byte and hold it until it is accepted.
    task automatic send_byte(input logic [7:0] b, input logic s, input logic e);
        bit ok;
        ok     = 1'b0;
        data   = b;
        sof    = s;
        eof    = e;
        data_v = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
        last_acc = cyc;
        @(posedge clk);
        #1;
        data_v = 1'b0;
        sof    = 1'b0;
        eof    = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] q[$], input int gap_after, input int gap_len,
                              output int first_acc);
        first_acc = 0;
        foreach (q[i]) begin
            send_byte(q[i], i == 0, i == q.size() - 1);
            if (i == 0) first_acc = last_acc;
            if (gap_after != 0 && i + 1 == gap_after) idle_cycles(gap_len);
        end
    endtask

    task automatic wait_eofs(input int target);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (eof_cnt >= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("eof_timeout", 64'd0, 64'd1);
        idle_cycles(1);
    endtask

    task automatic compare_stream(input string name);
        check({name, "_len"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("%s_b%0d", name, i),
                  {obs_q[i].a, obs_q[i].s, obs_q[i].e, obs_q[i].d},
                  {exp_q[i].a, exp_q[i].s, exp_q[i].e, exp_q[i].d});
        end
    endtask

    function automatic int span();
        if (obs_q.size() == 0) return 0;
        return obs_q[obs_q.size()-1].cyc - obs_q[0].cyc + 1;
    endfunction

    task automatic start_test();
        obs_q.delete();
        exp_q.delete();
        rdy_low = 0;
    endtask

    initial begin
        vec_t        tbl[4];
        logic [7:0]  q[$];
        logic [7:0]  a1[$];
        logic [31:0] fcs;
        int          fa;
        int          e0;
        int          a0;
        int          gap_after;
        int          gap_len;
        int          len;

        // Known-answer table.
        for (int i = 0; i < 9; i++) tbl[0].bytes[i] = 8'h31 + 8'(i);
        tbl[0].len = 9; tbl[0].gap_after = 0; tbl[0].gap_len = 0; tbl[0].fcs = 32'hCBF43926;
        tbl[1].bytes[0] = 8'h00;
        tbl[1].len = 1; tbl[1].gap_after = 0; tbl[1].gap_len = 0; tbl[1].fcs = 32'hD202EF8D;
        tbl[2].bytes[0] = 8'h61;
        tbl[2].len = 1; tbl[2].gap_after = 0; tbl[2].gap_len = 0; tbl[2].fcs = 32'hE8B7BE43;
        for (int i = 0; i < 9; i++) tbl[3].bytes[i] = 8'h31 + 8'(i);
        tbl[3].len = 9; tbl[3].gap_after = 4; tbl[3].gap_len = 3; tbl[3].fcs = 32'hCBF43926;

        // Reset state.
        #3;
        check("rst_outputs", {out_v, out_sof, out_eof, abort, out_data}, 64'd0);
        check("rst_in_ready", in_ready, 1'b1);
        idle_cycles(2);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(1);

        // Byte without sof while idle is dropped.
        start_test();
        send_byte(8'hAA, 1'b0, 1'b0);
        idle_cycles(3);
        check("idle_drop", obs_q.size(), 0);

        // Table-driven frames.
        for (int t = 0; t < 4; t++) begin
            start_test();
            q.delete();
            for (int i = 0; i < tbl[t].len; i++) q.push_back(tbl[t].bytes[i]);
            build_frame_exp(q, tbl[t].fcs);
            e0 = eof_cnt;
            send_frame(q, tbl[t].gap_after, tbl[t].gap_len, fa);
            wait_eofs(e0 + 1);
            compare_stream($sformatf("vec%0d", t));
            check($sformatf("vec%0d_ready_low", t), rdy_low, 4);
            check($sformatf("vec%0d_span", t), span(), tbl[t].len + 4 + tbl[t].gap_len);
            if (obs_q.size() > 0) check($sformatf("vec%0d_latency", t), obs_q[0].cyc, fa + 1);
        end

        // Back-to-back one-byte frames: second sof rides the in_ready rise.
        start_test();
        a1.delete();
        a1.push_back(8'h61);
        build_frame_exp(a1, 32'hE8B7BE43);
        build_frame_exp(a1, 32'hE8B7BE43);
        e0 = eof_cnt;
        send_frame(a1, 0, 0, fa);
        send_frame(a1, 0, 0, fa);
        wait_eofs(e0 + 2);
        compare_stream("b2b");
        check("b2b_span", span(), 10);
        check("b2b_ready_low", rdy_low, 8);

        // Restart with sof mid-frame.
        start_test();
        a0 = abort_cnt;
        e0 = eof_cnt;
        push_exp(8'h11, 1'b1, 1'b0, 1'b0);
        push_exp(8'h22, 1'b0, 1'b0, 1'b0);
        push_exp(8'h33, 1'b0, 1'b0, 1'b0);
        push_exp(8'h61, 1'b1, 1'b0, 1'b1);
        push_exp(8'h43, 1'b0, 1'b0, 1'b0);
        push_exp(8'hBE, 1'b0, 1'b0, 1'b0);
        push_exp(8'hB7, 1'b0, 1'b0, 1'b0);
        push_exp(8'hE8, 1'b0, 1'b1, 1'b0);
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        send_byte(8'h61, 1'b1, 1'b1);
        wait_eofs(e0 + 1);
        compare_stream("abort");
        check("abort_pulses", abort_cnt - a0, 1);
        check("abort_eofs", eof_cnt - e0, 1);

        // Reset during the second FCS byte.
        start_test();
        send_byte(8'h00, 1'b1, 1'b1);
        idle_cycles(2);
        check("pre_rst_byte", {out_v, out_data}, {1'b1, 8'hEF});
        e0 = eof_cnt;
        rst_n = 1'b0;
        #1;
        check("async_rst_outputs", {out_v, out_sof, out_eof, abort, out_data}, 64'd0);
        check("async_rst_in_ready", in_ready, 1'b1);
        idle_cycles(2);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(4);
        check("rst_no_eof", eof_cnt, e0);
        check("rst_ready_after", in_ready, 1'b1);
        start_test();
        q.delete();
        for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
        build_frame_exp(q, 32'hCBF43926);
        e0 = eof_cnt;
        send_frame(q, 0, 0, fa);
        wait_eofs(e0 + 1);
        compare_stream("post_rst");

        // Random frames against the model and the receive residue.
        for (int f = 0; f < 100; f++) begin
            start_test();
            q.delete();
            len = $urandom_range(1, 64);
            for (int i = 0; i < len; i++) q.push_back(8'($urandom_range(0, 255)));
            gap_after = (len > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : 0;
            gap_len   = (gap_after != 0) ? $urandom_range(1, 3) : 0;
            fcs = ~crc_raw(q);
            build_frame_exp(q, fcs);
            e0 = eof_cnt;
            send_frame(q, gap_after, gap_len, fa);
            wait_eofs(e0 + 1);
            compare_stream($sformatf("rnd%0d", f));
            check($sformatf("rnd%0d_span", f), span(), len + 4 + gap_len);
            a1.delete();
            foreach (obs_q[i]) a1.push_back(obs_q[i].d);
            check($sformatf("rnd%0d_residue", f), crc_raw(a1), RESIDUE);
        end

        check("stray_flags", stray, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_crc32_append
`default_nettype wire
